// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   alu_op_e    - 4-bit opcode encoding (9..15 are illegal)
//   FLAG_*      - bit positions inside the 4-bit flags word
//   alu_state_e - control FSM states of alu_pipe
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } alu_op_e;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_ILLEGAL = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative WIDTH x WIDTH unsigned shift-add multiplier.
// Bit 0 of the multiplier is folded in on the start edge, the remaining
// WIDTH-1 bits on the following edges, so done_o pulses WIDTH-1 cycles
// after start_i and product_o is then final.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, a_i, b_i     start pulse with operands
//   done_o                one-cycle pulse, product_o valid
//   product_o [2*WIDTH]   full product
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNTW-1:0]    bit_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
                mcand_q  <= {{WIDTH{1'b0}}, a_i} << 1;
                mplier_q <= b_i >> 1;
                bit_q    <= CNTW'(1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                bit_q    <= bit_q + 1'b1;
                if (bit_q == BIT_LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops load the output register on the accept edge; MUL (when
// built with ALU_MUL_EN) runs the iterative multiplier and loads after
// WIDTH cycles in MUL_RUN. Without ALU_MUL_EN opcode 8 is illegal.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake
//   opcode, operand_a, operand_b     operation and operands
//   out_valid/out_ready              result handshake
//   result [WIDTH], flags [4]        {illegal, overflow, carry, zero}
//
// state   | meaning
// IDLE    | accepting operations when the output slot is free
// MUL_RUN | multiplier iterating, counter 0..WIDTH-1, no acceptance
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic [3:0]       load_flags;

    assign accept = in_valid && in_ready;

    always_comb begin
        sum       = {1'b0, operand_a} + {1'b0, operand_b};
        diff      = {1'b0, operand_a} - {1'b0, operand_b};
        shamt     = operand_b[SHW-1:0];
        alu_res   = '0;
        alu_flags = '0;
        case (opcode)
            OP_ADD: begin
                alu_res               = sum[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = sum[WIDTH];
                alu_flags[FLAG_OVF]   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res               = diff[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = diff[WIDTH];
                alu_flags[FLAG_OVF]   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                                        (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_NOT:  alu_res = ~operand_a;
            OP_SHL:  alu_res = operand_a << shamt;
            OP_SHR:  alu_res = operand_a >> shamt;
            // MUL is handled by the FSM when enabled, otherwise it is illegal.
            default: alu_flags[FLAG_ILLEGAL] = 1'b1;
        endcase
        if (!alu_flags[FLAG_ILLEGAL]) begin
            alu_flags[FLAG_ZERO] = (alu_res == '0);
        end
    end

`ifdef ALU_MUL_EN
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    alu_state_e         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_start  = 1'b0;
        load       = 1'b0;
        load_res   = alu_res;
        load_flags = alu_flags;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        cnt_d     = '0;
                        state_d   = MUL_RUN;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST && mul_done) begin
                    load                   = 1'b1;
                    load_res               = mul_prod[WIDTH-1:0];
                    load_flags             = '0;
                    load_flags[FLAG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
                    load_flags[FLAG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
                    cnt_d                  = '0;
                    state_d                = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (operand_a),
        .b_i       (operand_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        load       = accept;
        load_res   = alu_res;
        load_flags = alu_flags;
    end
`endif

    // A load on the same edge as a consume keeps out_valid high.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (load) begin
            valid_d  = 1'b1;
            result_d = load_res;
            flags_d  = load_flags;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic [3:0]   exp_flags;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU from arithmetic rules; returns {illegal, ovf, carry, zero, result}.
    function automatic logic [19:0] ref_op(input int op, input longint a, input longint b, input bit mul_en);
        longint m    = longint'(1) << W;
        longint half = m / 2;
        longint sa   = (a >= half) ? a - m : a;
        longint sb   = (b >= half) ? b - m : b;
        longint r    = 0;
        longint s;
        bit z = 0, c = 0, v = 0, ill = 0;
        logic [W-1:0] r16;
        case (op)
            0: begin s = a + b; r = s % m; c = (s >= m); v = (sa + sb >= half) || (sa + sb < -half); end
            1: begin r = (a - b + m) % m; c = (a < b); v = (sa - sb >= half) || (sa - sb < -half); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = m - 1 - a;
            6: r = (a * (longint'(1) << (b % W))) % m;
            7: r = a / (longint'(1) << (b % W));
            8: begin
                if (mul_en) begin s = a * b; r = s % m; c = (s >= m); end
                else ill = 1;
            end
            default: ill = 1;
        endcase
        if (ill) begin r = 0; c = 0; v = 0; end
        z = !ill && (r == 0);
        r16 = r[W-1:0];
        return {ill, v, c, z, r16};
    endfunction

    vec_t vecs[12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, low, vcount, r;
        int busy;
        bit mv, mready, ld;
        logic [W-1:0] mres;
        logic [3:0]   mflg;
        logic [19:0]  pend;
        logic [W-1:0] corners[4];

        vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0011};
        vecs[1]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
        vecs[2]  = '{4'd4,  16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000};
        vecs[3]  = '{4'd6,  16'h0001, 16'h0013, 16'h0008, 4'b0000};
        vecs[4]  = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b1000};
        vecs[5]  = '{4'd7,  16'h8000, 16'h000F, 16'h0001, 4'b0000};
        vecs[6]  = '{4'd5,  16'h0000, 16'h1111, 16'hFFFF, 4'b0000};
        vecs[7]  = '{4'd2,  16'hF0F0, 16'h0F0F, 16'h0000, 4'b0001};
        vecs[8]  = '{4'd3,  16'h1234, 16'h0000, 16'h1234, 4'b0000};
        vecs[9]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0100};
        vecs[10] = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0010};
        vecs[11] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
        corners  = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

        // Reset
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0; out_ready = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel_result", result, 0);
        chk("rel_flags", flags, 0);
        chk("rel_out_valid", out_valid, 0);

        // Table vectors, back-to-back
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; opcode = vecs[i].op; operand_a = vecs[i].a; operand_b = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_out_valid", out_valid, 0);

        // MUL
        in_valid = 1'b1; opcode = 4'd8;
`ifdef ALU_MUL_EN
        operand_a = 16'h0100; operand_b = 16'h0100;
        #1;
        chk("mul_in_ready", in_ready, 1);
        @(posedge clk); #1;
        opcode = 4'd0; operand_a = 16'h0001; operand_b = 16'h0001;
        lat = 1; low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        chk("mul_latency", lat, W + 1);
        chk("mul_ready_low_cycles", low, W);
        chk("mul_result", result, 16'h0000);
        chk("mul_flags", flags, 4'b0011);
        @(posedge clk); #1;
        chk("post_mul_add_valid", out_valid, 1);
        chk("post_mul_add_result", result, 16'h0002);
`else
        operand_a = 16'h0003; operand_b = 16'h0005;
        #1;
        chk("mul_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("mul_ill_valid", out_valid, 1);
        chk("mul_ill_result", result, 16'h0000);
        chk("mul_ill_flags", flags, 4'b1000);
`endif
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure
        in_valid = 1'b1; opcode = 4'd2; operand_a = 16'hA5A5; operand_b = 16'h0FF0;
        @(posedge clk); #1;
        opcode = 4'd3; operand_a = 16'h00FF; operand_b = 16'hFF00; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            chk($sformatf("bp%0d_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_result", k), result, 16'h05A0);
            chk($sformatf("bp%0d_flags", k), flags, 4'b0000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_result", result, 16'hFFFF);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Reset during a pending operation
`ifdef ALU_MUL_EN
        in_valid = 1'b1; opcode = 4'd8; operand_a = 16'h0003; operand_b = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
        end
`else
        in_valid = 1'b1; opcode = 4'd0; operand_a = 16'h0003; operand_b = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        vcount = 0;
        for (int k = 0; k < 25; k++) begin
            if (out_valid) vcount++;
            @(posedge clk); #1;
        end
        chk("midrst_no_output", vcount, 0);
        in_valid = 1'b1; opcode = 4'd0; operand_a = 16'h0002; operand_b = 16'h0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after_rst_add_valid", out_valid, 1);
        chk("after_rst_add_result", result, 16'h0005);
        chk("after_rst_add_flags", flags, 4'b0000);
        @(posedge clk); #1;

        // Randomized run against the reference model
        busy = 0; mv = 1'b0; mres = '0; mflg = '0; pend = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_out_valid", out_valid, mv);
            if (mv) begin
                chk("rnd_result", result, mres);
                chk("rnd_flags", flags, mflg);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            opcode    = (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r);
            operand_a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            operand_b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            #1;
            mready = (busy == 0) && (!mv || out_ready);
            chk("rnd_in_ready", in_ready, mready);
            @(posedge clk);
            ld = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) ld = 1'b1;
            end else if (in_valid && mready) begin
                pend = ref_op(int'(opcode), longint'(operand_a), longint'(operand_b), MUL_EN);
                if (MUL_EN && opcode == 4'd8) busy = W;
                else ld = 1'b1;
            end
            if (ld) begin
                mv = 1'b1; mres = pend[W-1:0]; mflg = pend[19:16];
            end else if (out_ready) begin
                mv = 1'b0;
            end
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
